// File: rtl/mem_bridge.sv
`default_nettype none
// ============================================================================
// Module  : mem_bridge
// Brief   : Datapath-to-external-memory bridge with a one-entry read-hit
//           buffer and a bounded wait for the external acknowledge.
// Revision: 1.0 - initial release
// ============================================================================
module mem_bridge #(
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [12:0] address,
    input  logic [7:0]  write_data,
    input  logic        mem_read,
    input  logic        mem_write,
    output logic [7:0]  read_data,
    output logic        ready,
    output logic        busy,
    output logic        err,
    output logic        ext_req,
    output logic        ext_we,
    output logic [12:0] ext_addr,
    output logic [7:0]  ext_wdata,
    input  logic [7:0]  ext_rdata,
    input  logic        ext_ack
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Last REQ cycle index at which a missing ack turns into a timeout.
    localparam logic [3:0] c_cnt_last = 4'(TIMEOUT_CYCLES - 1);

    state_t      r_state;
    state_t      w_next_state;
    logic [3:0]  r_cnt;
    logic        r_buf_valid;
    logic [12:0] r_buf_tag;
    logic [7:0]  r_buf_data;
    logic        w_start;
    logic        w_hit;
    logic        w_timeout;

    assign w_start   = mem_read | mem_write;
    assign w_hit     = mem_read & ~mem_write & r_buf_valid & (r_buf_tag == address);
    assign w_timeout = (r_cnt == c_cnt_last);
    assign ready     = (r_state == S_DONE);
    assign busy      = (r_state != S_IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    w_next_state = w_hit ? S_DONE : S_REQ;
                end
            end
            S_REQ: begin
                if (ext_ack || w_timeout) begin
                    w_next_state = S_DONE;
                end
            end
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            read_data   <= 8'h00;
            err         <= 1'b0;
            ext_req     <= 1'b0;
            ext_we      <= 1'b0;
            ext_addr    <= 13'h0000;
            ext_wdata   <= 8'h00;
            r_cnt       <= 4'h0;
            r_buf_valid <= 1'b0;
            r_buf_tag   <= 13'h0000;
            r_buf_data  <= 8'h00;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        ext_addr  <= address;
                        ext_wdata <= write_data;
                        err       <= 1'b0;
                        r_cnt     <= 4'h0;
                        if (w_hit) begin
                            read_data <= r_buf_data;
                        end else begin
                            ext_req <= 1'b1;
                            ext_we  <= mem_write;
                        end
                    end
                end
                S_REQ: begin
                    if (ext_ack) begin
                        ext_req <= 1'b0;
                        ext_we  <= 1'b0;
                        if (!ext_we) begin
                            read_data   <= ext_rdata;
                            r_buf_data  <= ext_rdata;
                            r_buf_tag   <= ext_addr;
                            r_buf_valid <= 1'b1;
                        end else if (r_buf_tag == ext_addr) begin
                            // Keep the buffered copy coherent with the store.
                            r_buf_data <= ext_wdata;
                        end
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                        if (w_timeout) begin
                            ext_req     <= 1'b0;
                            ext_we      <= 1'b0;
                            err         <= 1'b1;
                            r_buf_valid <= 1'b0;
                            if (!ext_we) begin
                                read_data <= 8'hFF;
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_bridge.sv
`default_nettype none
// ============================================================================
// Module  : tb_mem_bridge
// Brief   : Self-checking bench for mem_bridge against a transaction-level
//           model of the hit buffer, latency and timeout behaviour.
// Revision: 1.0 - initial release
// ============================================================================
module tb_mem_bridge;

    localparam int TIMEOUT = 15;
    localparam int NO_ACK  = 99;

    logic        clk;
    logic        rst;
    logic [12:0] address;
    logic [7:0]  write_data;
    logic        mem_read;
    logic        mem_write;
    logic [7:0]  read_data;
    logic        ready;
    logic        busy;
    logic        err;
    logic        ext_req;
    logic        ext_we;
    logic [12:0] ext_addr;
    logic [7:0]  ext_wdata;
    logic [7:0]  ext_rdata;
    logic        ext_ack;

    int n_checks;
    int n_errors;

    // Transaction-level model state
    logic        m_valid;
    logic [12:0] m_tag;
    logic [7:0]  m_data;
    logic [7:0]  m_rd;
    logic        m_err;

    mem_bridge #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
        .clk        (clk),
        .rst        (rst),
        .address    (address),
        .write_data (write_data),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .read_data  (read_data),
        .ready      (ready),
        .busy       (busy),
        .err        (err),
        .ext_req    (ext_req),
        .ext_we     (ext_we),
        .ext_addr   (ext_addr),
        .ext_wdata  (ext_wdata),
        .ext_rdata  (ext_rdata),
        .ext_ack    (ext_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp_v, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_valid = 1'b0;
        m_tag   = 13'h0000;
        m_data  = 8'h00;
        m_rd    = 8'h00;
        m_err   = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        mem_read = 1'b0;
        mem_write = 1'b0;
        ext_ack = 1'b0;
        step();
        step();
        rst = 1'b1;
        model_reset();
    endtask

    // Idle cycles with stray acks that must not disturb anything.
    task automatic idle_gap(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            ext_ack   = 1'($urandom_range(0, 1));
            ext_rdata = 8'($urandom);
            step();
            ext_ack = 1'b0;
            chk("idle_quiet", 32'({ready, busy, ext_req}), 32'd0);
        end
    endtask

    task automatic do_txn(input logic rd, input logic wr, input logic [12:0] a,
                          input logic [7:0] wd, input int dly, input logic [7:0] rdat);
        logic is_wr;
        logic hit;
        logic acked;
        int   exp_lat;
        int   n;
        is_wr   = wr;
        hit     = rd && !wr && m_valid && (m_tag == a);
        acked   = (dly < TIMEOUT);
        exp_lat = hit ? 1 : ((acked ? dly + 1 : TIMEOUT) + 1);

        address    = a;
        write_data = wd;
        mem_read   = rd;
        mem_write  = wr;
        step();
        n = 1;
        while (!ready && n < 40) begin
            chk("req_hold", 32'({busy, ext_req, ext_we, ext_addr, ext_wdata}),
                32'({1'b1, 1'b1, is_wr, a, wd}));
            if (acked && n == dly + 1) begin
                ext_ack   = 1'b1;
                ext_rdata = rdat;
            end
            step();
            ext_ack   = 1'b0;
            ext_rdata = 8'($urandom);
            n++;
        end
        mem_read  = 1'b0;
        mem_write = 1'b0;
        chk("latency", 32'(n), 32'(exp_lat));
        if (!ready) begin
            do_reset();
        end else begin
            if (hit) begin
                m_rd  = m_data;
                m_err = 1'b0;
            end else if (acked) begin
                m_err = 1'b0;
                if (!is_wr) begin
                    m_valid = 1'b1;
                    m_tag   = a;
                    m_data  = rdat;
                    m_rd    = rdat;
                end else if (m_tag == a) begin
                    m_data = wd;
                end
            end else begin
                m_err   = 1'b1;
                m_valid = 1'b0;
                if (!is_wr) m_rd = 8'hFF;
            end
            chk("done_out", 32'({busy, ext_req, err}), 32'({1'b1, 1'b0, m_err}));
            if (!is_wr) chk("read_data", 32'(read_data), 32'(m_rd));
            ext_ack = 1'($urandom_range(0, 1));
            step();
            ext_ack = 1'b0;
            chk("one_pulse", 32'({ready, busy}), 32'd0);
            chk("err_hold", 32'(err), 32'(m_err));
        end
    endtask

    task automatic mid_reset();
        address  = 13'h0041;
        mem_read = 1'b1;
        step();
        step();
        chk("pre_rst_req", 32'(ext_req), 32'd1);
        rst = 1'b0;
        #1;
        chk("rst_async", 32'({ext_req, busy, ready}), 32'd0);
        mem_read = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst_no_ready", 32'({ready, ext_req}), 32'd0);
        end
        rst = 1'b1;
        model_reset();
        step();
        chk("post_rst_out", 32'({read_data, err, busy, ready}), 32'd0);
    endtask

    initial begin
        logic [12:0] ra;
        logic        rr;
        logic        rw;
        int          rd_dly;
        int          sel;
        n_checks   = 0;
        n_errors   = 0;
        rst        = 1'b0;
        address    = 13'h0000;
        write_data = 8'h00;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ext_rdata  = 8'h00;
        ext_ack    = 1'b0;
        model_reset();
        step();
        step();
        chk("reset_ctl", 32'({ready, busy, err, ext_req, ext_we}), 32'd0);
        chk("reset_data", 32'({read_data, ext_addr, ext_wdata}), 32'd0);
        rst = 1'b1;
        idle_gap(3);

        do_txn(1'b1, 1'b0, 13'h0040, 8'h00, 0, 8'h3C);
        chk("first_read", 32'(read_data), 32'h3C);
        do_txn(1'b1, 1'b0, 13'h0040, 8'h00, 0, 8'h99);
        chk("hit_read", 32'(read_data), 32'h3C);
        do_txn(1'b0, 1'b1, 13'h0040, 8'h77, 3, 8'h00);
        do_txn(1'b1, 1'b0, 13'h0040, 8'h00, 0, 8'h11);
        chk("hit_after_write", 32'(read_data), 32'h77);
        do_txn(1'b1, 1'b0, 13'h1FFF, 8'h00, NO_ACK, 8'h00);
        do_txn(1'b1, 1'b0, 13'h0040, 8'h00, 0, 8'h5A);
        do_txn(1'b1, 1'b1, 13'h0123, 8'hA5, 1, 8'h00);
        do_txn(1'b1, 1'b0, 13'h0200, 8'h00, 14, 8'hC3);
        do_txn(1'b1, 1'b0, 13'h0040, 8'h00, 0, 8'h3C);
        mid_reset();
        do_txn(1'b1, 1'b0, 13'h0040, 8'h00, 0, 8'h66);

        for (int k = 0; k < 150; k++) begin
            sel = int'($urandom_range(0, 3));
            case (sel)
                0:       ra = 13'h0040;
                1:       ra = 13'h0041;
                2:       ra = 13'h1FFF;
                default: ra = 13'($urandom);
            endcase
            sel = int'($urandom_range(0, 3));
            rr  = (sel != 2);
            rw  = (sel >= 2);
            sel = int'($urandom_range(0, 9));
            if (sel < 7)       rd_dly = int'($urandom_range(0, 3));
            else if (sel == 7) rd_dly = 14;
            else if (sel == 8) rd_dly = 13;
            else               rd_dly = NO_ACK;
            do_txn(rr, rw, ra, 8'($urandom), rd_dly, 8'($urandom));
            if ($urandom_range(0, 3) == 0) idle_gap(int'($urandom_range(1, 3)));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_bridge.md
MEM_BRIDGE -- requirements
Module: mem_bridge

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 15: maximum REQ-state cycles allowed without ext_ack before the bridge aborts.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 address  input  13  datapath memory address.
REQ-005 write_data  input  8  datapath store data.
REQ-006 mem_read  input  1  datapath read request, level.
REQ-007 mem_write  input  1  datapath write request, level.
REQ-008 read_data  output  8  registered load result, valid when ready=1.
REQ-009 ready  output  1  one-cycle transaction-complete pulse.
REQ-010 busy  output  1  high while a transaction is in flight (REQ or DONE).
REQ-011 err  output  1  timeout flag, valid with ready.
REQ-012 ext_req  output  1  external memory request, registered.
REQ-013 ext_we  output  1  external write enable, registered.
REQ-014 ext_addr  output  13  latched address.
REQ-015 ext_wdata  output  8  latched write data.
REQ-016 ext_rdata  input  8  external read data, valid with ext_ack.
REQ-017 ext_ack  input  1  external completion, one cycle.

Function
REQ-018 FSM states: IDLE, REQ, DONE.
REQ-019 IDLE: new requests are sampled only in this state; on a rising edge with mem_write=1 or mem_read=1, latch address and write_data into the ext_addr and ext_wdata registers.
REQ-020 If mem_read=1 and mem_write=1 on the same edge, the request is a write.
REQ-021 Read-hit buffer: one entry (8-bit tag-matched data, 13-bit tag, valid bit).
  - A read with valid=1 and tag=address goes IDLE->DONE directly with no ext_req.
  - On a hit, read_data = buffered data.
REQ-022 A miss read or any write goes IDLE->REQ.
  - ext_req=1 and ext_we=(write) from the first REQ cycle.
  - ext_req, ext_we, ext_addr and ext_wdata are held stable throughout REQ.
REQ-023 REQ with ext_ack=1 goes to DONE.
  - Read: read_data and the buffer data load ext_rdata; the buffer tag loads ext_addr; valid=1.
  - Write: if buffer tag=ext_addr, the buffer data loads ext_wdata; otherwise the buffer is unchanged.
  - ext_req=0 from the next cycle.
REQ-024 A 4-bit timeout counter clears on entry to REQ and increments each REQ cycle without ext_ack.
  - When it reaches TIMEOUT_CYCLES, go to DONE with err=1 and ext_req=0.
  - On a timed-out read, read_data=8'hFF.
  - Any timeout clears buffer valid.
REQ-025 If ext_ack arrives in the same cycle the counter reaches TIMEOUT_CYCLES, ack wins: err=0 and normal completion.
REQ-026 DONE: ready=1 for exactly one cycle, then IDLE unconditionally.
REQ-027 The requester deasserts mem_read/mem_write in the cycle ready=1. A request still high in IDLE starts a new transaction.
REQ-028 ext_ack in IDLE or DONE is ignored and has no state effect.
REQ-029 Timing from the request-sampling edge at cycle t:
  - Hit: ready=1 at cycle t+1.
  - Miss or write with ack in the first REQ cycle: ready=1 at cycle t+2.
  - Each cycle of ack delay adds one cycle.
REQ-030 err and read_data hold their values until the next accepted request.
REQ-031 busy=1 in REQ and DONE, 0 in IDLE.

Reset
REQ-032 On rst=0, asynchronously and regardless of state:
  - state=IDLE.
  - ext_req=0, ext_we=0, ext_addr=0, ext_wdata=0.
  - read_data=0, ready=0, busy=0, err=0.
  - counter=0 and buffer valid=0.
REQ-033 If reset asserts mid-REQ, ext_req drops in the same cycle. No ready pulse is issued for the aborted transaction.

Verification
REQ-034 Read 13'h0040, ext_ack with ext_rdata=8'h3C in the first REQ cycle -> ready at t+2, read_data=8'h3C, err=0.
REQ-035 Repeat read 13'h0040 -> ready at t+1, ext_req never asserted, read_data=8'h3C.
REQ-036 Write 8'h77 to 13'h0040 with ack after 3 cycles, then read 13'h0040 -> ext_we=1 and ext_wdata=8'h77 stable for 3 cycles; the read hits with 8'h77.
REQ-037 Read 13'h1FFF, ext_ack never asserted -> ready after 15 REQ cycles with err=1, read_data=8'hFF, and the next read of 13'h0040 misses.
REQ-038 mem_read=1 and mem_write=1 together -> write performed (ext_we=1).
REQ-039 ext_ack on the 15th REQ cycle -> normal completion with err=0.
REQ-040 rst=0 mid-REQ -> ext_req=0 immediately, no ready pulse, and the buffer is invalid afterward.
